// File: rtl/big_digit_scan.sv
// Frame scanner for the large-digit readout: walks the 128x64 OLED frame,
// drives the big-digit mapper and streams ROM bytes over valid/ready.
module big_digit_scan #(
    parameter int DIGITS    = 5,
    parameter int ROW_FIRST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIGITS*7-1:0]   digits_in,
    output logic [10:0]           col_all,
    output logic [2:0]            row_all,
    output logic [6:0]            ascii,
    input  logic [7:0]            rom_data,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int DW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          page_q, page_d;
    logic [6:0]          col_q, col_d;
    logic [4:0]          dcol_q, dcol_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [DIGITS*7-1:0] snap_q, snap_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic                in_win_s;
    logic                last_s;
    logic [6:0]          ascii_s;

    // Window decode and digit selection from the current counters
    always_comb begin
        in_win_s = (page_q >= 3'(ROW_FIRST)) && (dig_q < DW'(DIGITS));
        last_s   = (page_q == 3'd7) && (col_q == 7'd127);
        ascii_s  = 7'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (in_win_s && (dig_q == DW'(k))) begin
                ascii_s = snap_q[k*7 +: 7];
            end else begin
                ascii_s = ascii_s;
            end
        end
    end

    assign col_all    = {1'b0, page_q, col_q};
    assign row_all    = page_q;
    assign ascii      = ascii_s;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Next-state logic for the FSM, counters and output registers
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        col_d        = col_q;
        dcol_d       = dcol_q;
        dig_d        = dig_q;
        snap_d       = snap_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = digits_in;
                    page_d  = 3'd0;
                    col_d   = 7'd0;
                    dcol_d  = 5'd0;
                    dig_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                out_data_d  = in_win_s ? rom_data : 8'h00;
                out_last_d  = last_s;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        if (col_q == 7'd127) begin
                            col_d  = 7'd0;
                            dcol_d = 5'd0;
                            dig_d  = '0;
                            page_d = page_q + 3'd1;
                        end else begin
                            col_d = col_q + 7'd1;
                            if (dcol_q == 5'd23) begin
                                dcol_d = 5'd0;
                                // dig parks at DIGITS once past the last digit
                                if (dig_q != DW'(DIGITS)) begin
                                    dig_d = dig_q + DW'(1);
                                end else begin
                                    dig_d = dig_q;
                                end
                            end else begin
                                dcol_d = dcol_q + 5'd1;
                            end
                        end
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, snapshot and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            page_q       <= 3'd0;
            col_q        <= 7'd0;
            dcol_q       <= 5'd0;
            dig_q        <= '0;
            snap_q       <= '0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            col_q        <= col_d;
            dcol_q       <= dcol_d;
            dig_q        <= dig_d;
            snap_q       <= snap_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/big_digit_scan.md
# big_digit_scan

Frame scanner for the large-digit speed readout. On `start` it snapshots a row of ASCII digits and walks the whole 128×64 OLED frame, page by page and column by column. For each byte it drives the `col_all` / `row_all` / `ascii` inputs of the big-digit address mapper, collects the byte returned by `big_digit_rom`, and streams it downstream to the display link writer over a valid/ready handshake. Bytes outside the digit window are emitted as blank (0x00).

## Interface
Parameters:
- `DIGITS`, default 5: number of 24-column big digits, placed left-aligned from column 0. Legal range 1..5.
- `ROW_FIRST`, default 2: first page of the 6-page digit window. The window is pages `ROW_FIRST`..7.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle frame request; sampled only in IDLE.
- `digits_in` in DIGITS*7: packed ASCII; digit k occupies bits [7k+6:7k]; digit 0 is leftmost.
- `col_all` out 11: linear byte index page*128+column, zero-extended. Feeds the mapper.
- `row_all` out 3: current page 0..7. Feeds the mapper.
- `ascii` out 7: snapshot digit for the current column; 7'd0 outside the window.
- `rom_data` in 8: `big_digit_rom` output, registered ROM with 1-cycle read latency.
- `out_data` out 8: display byte, LSB = top pixel of the page.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts when high together with `out_valid`.
- `out_last` out 1: qualifies the final byte of the frame (page 7, column 127).
- `busy` out 1: high from the cycle after `start` is accepted until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- **State machine:** IDLE → FETCH → LATCH → SEND → (FETCH | DONE); DONE → IDLE.
- **IDLE:** on `start`, capture `digits_in` into the snapshot register, clear all counters, and go to FETCH. `start` in any other state is ignored.
- **Counters:**
  - `page` counts 0..7.
  - `col` counts 0..127.
  - `dcol` counts 0..23 and wraps to 0 while incrementing `dig`.
  - `dig` counts 0..DIGITS and saturates at DIGITS.
  - All counters clear when `col` wraps to 0, and `page` increments at that point.
  - There is no divider; the digit position comes from `dcol`/`dig`.
- **Window:** `in_win = (page >= ROW_FIRST) && (dig < DIGITS)`.
- **Mapper outputs:**
  - `col_all = {1'b0, page, col}` and `row_all = page`. Both are combinational from the counters and stable from FETCH through SEND.
  - `ascii = in_win ? snapshot[dig] : 0`.
- **FETCH:** the address is presented; the ROM samples it at the end of this cycle.
- **LATCH:** `out_data <= in_win ? rom_data : 8'h00`. `out_last` is registered at the same time.
- **SEND:** `out_valid` is high and `out_data` / `out_last` are held until `out_ready`. On handshake:
  - if this was the last byte, go to DONE;
  - otherwise advance the counters and go to FETCH.
- **DONE:** `frame_done` is high for one cycle, `busy` drops, and the FSM returns to IDLE.
- **Frame contents:** a frame is exactly 1024 bytes, page-major. Columns DIGITS*24..127 and pages 0..ROW_FIRST-1 are always 0x00.
- **Reset values:**
  - Asserting `rst` at any time forces IDLE and clears the counters and snapshot.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `frame_done`=0, `col_all`=0, `row_all`=0, `ascii`=0.
  - A partial frame is abandoned, with no `frame_done`.

## Timing
- `start` is accepted at edge T0.
- FETCH occupies T0→T1, LATCH T1→T2, and the first `out_valid` is visible after T2, i.e. 3 cycles after `start`.
- Each byte costs 3 cycles plus any stall cycles (`out_ready` low in SEND). With `out_ready` tied high, a full frame is 3072 cycles from `start` to the last handshake, and `frame_done` follows 1 cycle later.
- `out_data` and `out_last` do not change while `out_valid` is high and `out_ready` is low.
- `out_valid` never asserts in IDLE, FETCH, LATCH or DONE.
- A `start` coinciding with `frame_done` is ignored. A new frame needs `start` while in IDLE.

## Test plan
- **Reset:** assert `rst` mid-SEND at byte 500 → all outputs 0 next cycle, no `frame_done`. A following `start` produces a full 1024-byte frame from page 0, column 0.
- **Full frame:** `digits_in`="12345", `out_ready`=1.
  - 1024 handshakes; first byte at cycle 3; `out_last` only on byte 1023; `frame_done` at cycle 3073.
  - Pages 0–1 all 0x00.
- **Address check:** at page 2, column 30 → `col_all`=286, `row_all`=2, `ascii`=0x32 ('2'). At page 7, column 119 → `ascii`=0x35. At page 4, column 120 → `ascii`=0 and `out_data`=0x00 even if the ROM returns 0xFF.
- **Backpressure:** drive `out_ready` with a random 30% duty → byte sequence identical to the unstalled run, with `out_data` held stable during every stall.
- **Snapshot:** change `digits_in` to "99999" mid-frame → the rest of the frame still uses "12345", and the next frame uses "99999".
- **Start filtering:** pulse `start` while busy and again on the `frame_done` cycle → ignored; exactly one frame is produced.
